// File: rtl/sha512_padder_if.sv
// Handshake bundle between the line source, the SHA-512 padder and the core.
// The master side drives lines and core-ready; the slave side is the padder.
interface sha512_padder_if #(
    parameter int LEN_W = 32
);
    logic             start;
    logic [LEN_W-1:0] num_lines;
    logic [511:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [511:0]     block [2];
    logic             block_valid;
    logic             ready;
    logic             block_last;
    logic             busy;
    logic             done;

    modport master (
        output start, num_lines, in_data, in_valid, ready,
        input  in_ready, block, block_valid, block_last, busy, done
    );

    modport slave (
        input  start, num_lines, in_data, in_valid, ready,
        output in_ready, block, block_valid, block_last, busy, done
    );
endinterface

// File: rtl/sha512_padder.sv
// Packs 512-bit message lines into 1024-bit SHA-512 blocks and appends
// the 0x80 terminator plus the 128-bit big-endian message bit length.
module sha512_padder #(
    parameter int LEN_W = 32
) (
    input logic            clk,
    input logic            reset,
    sha512_padder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, FILL0, FILL1, EMIT, PAD, DONE
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [LEN_W-1:0] remaining;
    logic [127:0]     bitLen;
    logic [511:0]     blockReg [2];
    logic             last;
    logic             padPending;
    logic             lastLine;

    // Length goes in bytes 48..63, most significant byte first.
    function automatic logic [511:0] padLine(
        input logic [127:0] len,
        input logic         marker
    );
        logic [511:0] line;
        line = '0;
        line[7:0] = marker ? 8'h80 : 8'h00;
        for (int j = 0; j < 16; j++) begin
            line[8*(48+j) +: 8] = len[8*(15-j) +: 8];
        end
        return line;
    endfunction

    assign lastLine     = (remaining == LEN_W'(1));
    assign bus.block[0] = blockReg[0];
    assign bus.block[1] = blockReg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = (bus.num_lines == '0) ? PAD : FILL0;
                end
            end
            FILL0: begin
                if (bus.in_valid) begin
                    nextState = lastLine ? EMIT : FILL1;
                end
            end
            FILL1: begin
                if (bus.in_valid) begin
                    nextState = EMIT;
                end
            end
            EMIT: begin
                if (bus.ready) begin
                    if (last) begin
                        nextState = DONE;
                    end else if (padPending) begin
                        nextState = PAD;
                    end else begin
                        nextState = FILL0;
                    end
                end
            end
            PAD:     nextState = EMIT;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = 1'b0;
        bus.block_valid = 1'b0;
        bus.block_last  = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        unique case (1'b1)
            (state == FILL0),
            (state == FILL1): begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            (state == EMIT): begin
                bus.block_valid = 1'b1;
                bus.block_last  = last;
                bus.busy        = 1'b1;
            end
            (state == PAD):  bus.busy = 1'b1;
            (state == DONE): bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining   <= '0;
            bitLen      <= '0;
            blockReg[0] <= '0;
            blockReg[1] <= '0;
            last        <= 1'b0;
            padPending  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining  <= bus.num_lines;
                        bitLen     <= {{(119-LEN_W){1'b0}}, bus.num_lines, 9'b0};
                        last       <= 1'b0;
                        padPending <= 1'b0;
                    end
                end
                FILL0: begin
                    if (bus.in_valid) begin
                        blockReg[0] <= bus.in_data;
                        remaining   <= remaining - LEN_W'(1);
                        if (lastLine) begin
                            blockReg[1] <= padLine(bitLen, 1'b1);
                            last        <= 1'b1;
                        end
                    end
                end
                FILL1: begin
                    if (bus.in_valid) begin
                        blockReg[1] <= bus.in_data;
                        remaining   <= remaining - LEN_W'(1);
                        if (lastLine) begin
                            padPending <= 1'b1;
                        end
                    end
                end
                // Message ended on a block boundary: length-only block follows.
                PAD: begin
                    blockReg[0] <= padLine('0, 1'b1);
                    blockReg[1] <= padLine(bitLen, 1'b0);
                    last        <= 1'b1;
                    padPending  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha512_padder.sv
// Randomized scoreboard bench for sha512_padder against a byte-level
// FIPS 180-4 padding model.
module tb_sha512_padder;
    typedef struct {
        logic [511:0] b0;
        logic [511:0] b1;
        logic         last;
    } expT;

    logic clk = 1'b0;
    logic reset;

    sha512_padder_if #(.LEN_W(32)) bus ();

    sha512_padder #(.LEN_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    expT          sbq[$];
    logic [511:0] lineQ[$];
    int           doneCount = 0;
    int           inReadyCnt = 0;
    int           xferCount = 0;
    logic [511:0] lastB0;
    logic [511:0] lastB1;
    logic         lastLast;
    bit           holdReq = 0;

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] randLine();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Reference: byte stream + 0x80 + zeros to 112 mod 128 + 16-byte length.
    task automatic pushModel(int n);
        byte unsigned m[$];
        logic [127:0] bl;
        expT          e;
        int           nb;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 64; k++) m.push_back(lineQ[i][8*k +: 8]);
        bl = 128'(n) * 128'd512;
        m.push_back(8'h80);
        while (m.size() % 128 != 112) m.push_back(8'h00);
        for (int j = 15; j >= 0; j--) m.push_back(bl[8*j +: 8]);
        nb = m.size() / 128;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 64; k++) begin
                e.b0[8*k +: 8] = m[128*b + k];
                e.b1[8*k +: 8] = m[128*b + 64 + k];
            end
            e.last = (b == nb - 1);
            sbq.push_back(e);
        end
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.done) doneCount++;
                if (bus.in_ready) inReadyCnt++;
                if (bus.block_valid && bus.ready) begin
                    xferCount++;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: unexpected block, queue empty");
                    end else begin
                        e = sbq.pop_front();
                        chk("block0", bus.block[0], e.b0);
                        chk("block1", bus.block[1], e.b1);
                        chk("block_last", 512'(bus.block_last), 512'(e.last));
                        lastB0   = bus.block[0];
                        lastB1   = bus.block[1];
                        lastLast = bus.block_last;
                    end
                end
            end
        end
    end

    // Core-side ready: random, with an optional 10-cycle stall on the next block.
    initial begin
        logic [511:0] s0;
        logic [511:0] s1;
        bus.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (holdReq && bus.block_valid) begin
                holdReq   = 0;
                bus.ready = 1'b0;
                s0 = bus.block[0];
                s1 = bus.block[1];
                repeat (10) begin
                    @(negedge clk);
                    chk("hold block0 stable", bus.block[0], s0);
                    chk("hold block1 stable", bus.block[1], s1);
                    chk("hold valid", 512'(bus.block_valid), 512'(1));
                    chk("hold in_ready", 512'(bus.in_ready), 512'(0));
                    @(posedge clk);
                    #1;
                end
            end
            bus.ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic runMessage(int n, bit allAA, bit startMid);
        int  i;
        int  budget;
        int  doneBefore;
        int  irBefore;
        int  expBlocks;
        bit  acc;
        bit  midSent;
        lineQ.delete();
        for (int k = 0; k < n; k++)
            lineQ.push_back(allAA ? {64{8'hAA}} : randLine());
        pushModel(n);
        expBlocks  = (n % 2 == 1) ? (n + 1) / 2 : n / 2 + 1;
        xferCount  = 0;
        doneBefore = doneCount;
        irBefore   = inReadyCnt;
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.num_lines = 32'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        i       = 0;
        budget  = 0;
        midSent = 0;
        while (i < n && budget < 1000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = lineQ[i];
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (acc) i++;
            if (startMid && !midSent && i == 1) begin
                midSent       = 1;
                bus.start     = 1'b1;
                bus.num_lines = 32'd5;
            end
            budget++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL feed timeout: accepted %0d of %0d lines", i, n);
        end
        budget = 0;
        while (doneCount == doneBefore && budget < 1000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        chk("done pulse", 512'(doneCount - doneBefore), 512'(1));
        chk("block count", 512'(xferCount), 512'(expBlocks));
        chk("scoreboard drained", 512'(sbq.size()), 512'(0));
        if (n == 0) chk("no in_ready for empty msg", 512'(inReadyCnt - irBefore), 512'(0));
        sbq.delete();
    endtask

    task automatic checkIdle(string tag);
        chk({tag, " in_ready"}, 512'(bus.in_ready), 512'(0));
        chk({tag, " block_valid"}, 512'(bus.block_valid), 512'(0));
        chk({tag, " block_last"}, 512'(bus.block_last), 512'(0));
        chk({tag, " busy"}, 512'(bus.busy), 512'(0));
        chk({tag, " done"}, 512'(bus.done), 512'(0));
        chk({tag, " block0"}, bus.block[0], 512'(0));
        chk({tag, " block1"}, bus.block[1], 512'(0));
    endtask

    initial begin
        int dc;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.num_lines = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkIdle("reset");

        runMessage(1, 1'b1, 1'b0);
        chk("T1 block0", lastB0, {64{8'hAA}});
        chk("T1 byte0", 512'(lastB1[7:0]), 512'(8'h80));
        chk("T1 byte62", 512'(lastB1[503:496]), 512'(8'h02));
        chk("T1 byte63", 512'(lastB1[511:504]), 512'(8'h00));
        chk("T1 last", 512'(lastLast), 512'(1));

        runMessage(2, 1'b0, 1'b0);
        chk("T2 L byte0", 512'(lastB1[7:0]), 512'(8'h00));
        chk("T2 L byte62", 512'(lastB1[503:496]), 512'(8'h04));
        chk("T2 P0", lastB0, 512'(8'h80));

        runMessage(0, 1'b0, 1'b0);
        chk("T3 P0", lastB0, 512'(8'h80));
        chk("T3 L", lastB1, 512'(0));

        holdReq = 1;
        runMessage(3, 1'b0, 1'b0);
        chk("T4 byte62", 512'(lastB1[503:496]), 512'(8'h06));

        runMessage(2, 1'b0, 1'b1);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(0, 7);
            runMessage(n, 1'b0, (n >= 2) && ($urandom_range(0, 1) == 1));
        end

        dc = doneCount;
        lineQ.delete();
        lineQ.push_back(randLine());
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.num_lines = 32'd4;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = lineQ[0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("T6 in FILL1", 512'(bus.in_ready && bus.busy), 512'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkIdle("T6 post-reset");
        chk("T6 no done", 512'(doneCount - dc), 512'(0));
        runMessage(1, 1'b1, 1'b0);
        chk("T6 block0", lastB0, {64{8'hAA}});
        chk("T6 byte62", 512'(lastB1[503:496]), 512'(8'h02));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
